fetch_stage: RTL

Instruction fetch stage of the single-issue CPU. It owns the program counter, drives the synchronous instruction ROM, and presents the instruction fetched for each slot in the IF/ID pipeline register, together with its PC and a valid bit. The IF/ID opcode field feeds `controlUnit` directly. A one-entry hold buffer prevents any fetched instruction from being lost or duplicated across decode stalls. A taken branch redirects fetch and squashes all wrong-path fetches.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_hold_buf.sv | 27 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field placement and the
// fetch slot payload carried by IF/ID, the hold buffer and the response tracker.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_W       = 10;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned OPCODE_MSB = 31;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_slot_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks the ROM response arriving while decode is stalled
// and hands it back once the stall lifts.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               capture,
  input  logic               drain,
  input  logic [INSTR_W-1:0] cap_instr,
  input  logic [PC_W-1:0]    cap_pc,
  output fetch_slot_t        slot
);

  // Flush (redirect) discards the parked instruction; capture and drain never coincide.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else if (capture) begin
      slot <= '{valid: 1'b1, instr: cap_instr, pc: cap_pc};
    end else if (drain) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM
// and fills the IF/ID register. ADDR_W/INSTR_W must match cpu_pkg::PC_W/INSTR_W.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [3:0]         if_id_opcode,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_slot_t       rsp_q, rsp_d;
  fetch_slot_t       if_id_q, if_id_d;
  fetch_slot_t       hold_q;
  fetch_slot_t       src_c;
  logic              hold_flush_c;
  logic              hold_capture_c;
  logic              hold_drain_c;

  assign imem_en   = !rst && !stall && !branch_taken;
  assign imem_addr = pc_q;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .flush     (hold_flush_c),
    .capture   (hold_capture_c),
    .drain     (hold_drain_c),
    .cap_instr (imem_rdata),
    .cap_pc    (rsp_q.pc),
    .slot      (hold_q)
  );

  // A parked instruction is always older than anything on the ROM bus.
  always_comb begin
    src_c       = rsp_q;
    src_c.instr = imem_rdata;
    if (hold_q.valid) begin
      src_c = hold_q;
    end
  end

  // Priority below reset: redirect, then stall, then normal advance.
  always_comb begin
    pc_d           = pc_q;
    rsp_d          = rsp_q;
    if_id_d        = if_id_q;
    hold_flush_c   = 1'b0;
    hold_capture_c = 1'b0;
    hold_drain_c   = 1'b0;

    if (branch_taken) begin
      pc_d          = branch_target;
      rsp_d.valid   = 1'b0;
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
      hold_flush_c  = 1'b1;
    end else if (stall) begin
      rsp_d.valid    = 1'b0;
      hold_capture_c = rsp_q.valid && !hold_q.valid;
    end else begin
      if_id_d = src_c;
      if (!src_c.valid) begin
        if_id_d.instr = NOP_INSTR;
      end
      hold_drain_c = 1'b1;
      pc_d         = pc_q + ADDR_W'(1);
      rsp_d        = '{valid: 1'b1, instr: NOP_INSTR, pc: pc_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rsp_q   <= '0;
      if_id_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rsp_q   <= rsp_d;
      if_id_q <= if_id_d;
    end
  end

  assign if_id_instr  = if_id_q.instr;
  assign if_id_opcode = opcode_of(if_id_q.instr);
  assign if_id_pc     = if_id_q.pc;
  assign if_id_valid  = if_id_q.valid;

endmodule
